// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the minimum supported operand width.
package serial_subtractor_pkg;

  localparam int MIN_WIDTH = 2;

  // Two-bit encoding; the unused code 2'd3 is treated as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between the operand source (master) and the serial
// subtractor (slave).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_bit_cell.sv
// Combinational one-bit full subtractor: diff = a - b - bin, with borrow out.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per cycle LSB first,
// with a registered borrow between bit positions.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < MIN_WIDTH) begin : g_width_check
      $error("serial_subtractor: WIDTH must be at least 2");
    end
  endgenerate

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             borrow;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] res_next;
  logic             accept;

  fs_bit_cell u_cell (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (borrow),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // The newest cell output enters at the MSB; after the last bit this is the full result.
  assign res_next = {cell_diff, res};

  // A new request is only seen when no subtraction is in flight; DONE counts as free.
  assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

  // NOTE: every register below is written with <= so all of them update from the
  // same pre-edge values, which is what keeps the shift/borrow chain consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ra     <= '0;
      rb     <= '0;
      borrow <= 1'b0;
      res    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            ra     <= bus.a;
            rb     <= bus.b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_RUN: begin
          ra     <= ra >> 1;
          rb     <= rb >> 1;
          res    <= res_next[WIDTH-1:1];
          borrow <= cell_bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Results are published only here, so they hold across DONE, IDLE and the next RUN.
            diff_q <= res_next;
            bout_q <= cell_bout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the scenarios and
// a 3-bit instance checked over every operand pair.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(3)) bus3 ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on the 8-bit instance; lat = edges from accept to done, -1 on timeout.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output logic [7:0] d, output logic bo);
    bus8.a     = av;
    bus8.b     = bv;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus8.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    d  = bus8.diff;
    bo = bus8.bout;
    step();
  endtask

  task automatic run3(input logic [2:0] av, input logic [2:0] bv,
                      output int lat, output logic [2:0] d, output logic bo);
    bus3.a     = av;
    bus3.b     = bv;
    bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus3.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    d  = bus3.diff;
    bo = bus3.bout;
    step();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({bus8.busy, bus8.done, bus8.bout, bus8.diff} !== 11'h000) begin
      bad++;
      $display("FAIL reset8: busy=%b done=%b bout=%b diff=%h, required all 0",
               bus8.busy, bus8.done, bus8.bout, bus8.diff);
    end
    total++;
    if ({bus3.busy, bus3.done, bus3.bout, bus3.diff} !== 6'h00) begin
      bad++;
      $display("FAIL reset3: busy=%b done=%b bout=%b diff=%h, required all 0",
               bus3.busy, bus3.done, bus3.bout, bus3.diff);
    end
    step();
    step();
    rst = 1'b0;
    step();
    total++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus8.busy, bus8.done);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] d;
    logic bo;
    run8(8'h5A, 8'h3C, lat, d, bo);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d edges, required 8", lat);
    end
    total++;
    if ({bo, d} !== 9'h01E) begin
      bad++;
      $display("FAIL basic_result: got bout=%b diff=%h, required bout=0 diff=1e", bo, d);
    end
    total++;
    if ({bus8.busy, bus8.done, bus8.diff} !== 10'h01E) begin
      bad++;
      $display("FAIL basic_idle_hold: busy=%b done=%b diff=%h, required 0 0 1e",
               bus8.busy, bus8.done, bus8.diff);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] va [3] = '{8'h00, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'hFF};
    logic [8:0] ex [3] = '{9'h1FF, 9'h000, 9'h101};
    int lat;
    logic [7:0] d;
    logic bo;
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], lat, d, bo);
      total++;
      if ({bo, d} !== ex[i] || lat !== 8) begin
        bad++;
        $display("FAIL boundary_%0d: a=%h b=%h got bout=%b diff=%h lat=%0d, required bout=%b diff=%h lat=8",
                 i, va[i], vb[i], bo, d, lat, ex[i][8], ex[i][7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    int lat;
    bus8.a     = 8'h10;
    bus8.b     = 8'h20;
    bus8.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_done = (k % 9 == 0);
      total++;
      if (bus8.done !== exp_done || bus8.busy !== !exp_done) begin
        bad++;
        $display("FAIL b2b_cycle_%0d: done=%b busy=%b, required done=%b busy=%b",
                 k, bus8.done, bus8.busy, exp_done, !exp_done);
      end
      if (exp_done) begin
        total++;
        if ({bus8.bout, bus8.diff} !== 9'h1F0) begin
          bad++;
          $display("FAIL b2b_result_%0d: bout=%b diff=%h, required bout=1 diff=f0",
                   k, bus8.bout, bus8.diff);
        end
      end
    end
    bus8.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus8.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat !== 7 || {bus8.bout, bus8.diff} !== 9'h1F0) begin
      bad++;
      $display("FAIL b2b_third: lat=%0d bout=%b diff=%h, required lat=7 bout=1 diff=f0",
               lat, bus8.bout, bus8.diff);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int lat;
    logic held_ok;
    bus8.a     = 8'h80;
    bus8.b     = 8'h01;
    bus8.start = 1'b1;
    step();
    lat     = -1;
    held_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      bus8.start = i[0];
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      step();
      if (bus8.done === 1'b1) begin
        bus8.start = 1'b0;
        lat = i;
        break;
      end
      if (bus8.busy !== 1'b1 || bus8.diff !== 8'hF0 || bus8.bout !== 1'b1) held_ok = 1'b0;
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("FAIL ignore_hold: busy dropped or outputs moved during RUN, required busy=1 diff=f0 bout=1");
    end
    total++;
    if (lat !== 8 || {bus8.bout, bus8.diff} !== 9'h07F) begin
      bad++;
      $display("FAIL ignore_result: lat=%0d bout=%b diff=%h, required lat=8 bout=0 diff=7f",
               lat, bus8.bout, bus8.diff);
    end
    step();
    total++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      bad++;
      $display("FAIL ignore_no_requeue: busy=%b done=%b, required 0 0", bus8.busy, bus8.done);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] d;
    logic bo;
    logic saw_done;
    bus8.a     = 8'h55;
    bus8.b     = 8'hAA;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    total++;
    if ({bus8.busy, bus8.done, bus8.bout, bus8.diff} !== 11'h000) begin
      bad++;
      $display("FAIL midreset_clear: busy=%b done=%b bout=%b diff=%h, required all 0",
               bus8.busy, bus8.done, bus8.bout, bus8.diff);
    end
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL midreset_no_done: done or busy seen after abort, required both 0");
    end
    run8(8'hC3, 8'h3C, lat, d, bo);
    total++;
    if (lat !== 8 || {bo, d} !== 9'h087) begin
      bad++;
      $display("FAIL midreset_next: lat=%0d bout=%b diff=%h, required lat=8 bout=0 diff=87",
               lat, bo, d);
    end
  endtask

  task automatic test_exhaustive3();
    int lat;
    int good;
    logic [2:0] d;
    logic bo;
    logic [3:0] golden;
    good = 0;
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        golden = {1'b0, 3'(ia)} - {1'b0, 3'(ib)};
        run3(3'(ia), 3'(ib), lat, d, bo);
        total++;
        if ({bo, d} !== golden || lat !== 3) begin
          bad++;
          $display("FAIL w3_%0d_%0d: got bout=%b diff=%0d lat=%0d, required bout=%b diff=%0d lat=3",
                   ia, ib, bo, d, lat, golden[3], golden[2:0]);
        end else begin
          good++;
        end
      end
    end
    $display("width3 exhaustive: %0d/64 pairs correct", good);
  endtask

  initial begin
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus3.start = 1'b0;
    bus3.a     = '0;
    bus3.b     = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_exhaustive3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
